game_move_sequencer: RTL and testbench
======================================

Name: game_move_sequencer

Overview:
Owns the 4x4 game board register and sequences one shared external row push/merge unit to execute a move command. Each line (row or column) is fed through the merge unit once, one line per cycle, and the result is written back. If the board changed, the block then spawns a new tile in a pseudo-randomly chosen empty cell and reports completion. It sits between the input/command logic and the single combinational merge datapath.

Parameters:
SPAWN_SCAN, 16, maximum cells examined while searching for an empty cell (one per cycle).
WIN_EXP, 11, tile exponent that sets the won flag (11 = 2048).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
move_valid  in  1  move request
move_dir  in  2  0=left, 1=right, 2=up, 3=down
move_ready  out  1  high in IDLE only
load_valid  in  1  load board (new game / restore)
load_board  in  64  board to load
rnd  in  5  random bits: [3:0] spawn start index, [4] spawn value select
merge_row  out  16  line driven to merge unit
merge_push_right  out  1  merge direction
merge_result  in  16  merge unit output (combinational from merge_row/merge_push_right)
board  out  64  current board; cell (r,c) = board[(r*4+c)*4 +: 4], exponent, 0 = empty
done  out  1  one-cycle pulse at end of a move
moved  out  1  valid with done; 1 if the board changed
won  out  1  sticky: any cell == WIN_EXP

Behaviour:
- Reset (asynchronous, any state including mid-move): board=0, state=IDLE, move_ready=1, merge_row=0, merge_push_right=0, done=0, moved=0, won=0; the line index, changed accumulator and scan counter are cleared.
- States: IDLE, PROC, SPAWN, DONE.
- IDLE: if load_valid, board<=load_board, won<=0; stay in IDLE. A load takes priority over a simultaneous move_valid, and the move is not accepted. Otherwise, if move_valid, latch move_dir, set line index k=0, clear changed, go to PROC. load_valid and move_valid are ignored outside IDLE.
- PROC (exactly 4 cycles, k=0..3):
  - left/right: line = row k = board[k*16 +: 16], cell c at bits c*4.
  - up/down: line = column k, with cell r at bits r*4 taken from (r,k).
  - merge_push_right = 1 for right/down, 0 for left/up.
  - Each cycle, merge_result is written back into the same line positions at the clock edge.
  - changed |= (merge_result != merge_row).
  - After k=3: go to SPAWN if changed, else DONE.
  - merge_row is 0 in every state except PROC.
- SPAWN:
  - Scan pointer p starts at rnd[3:0], sampled on the PROC->SPAWN transition.
  - Each cycle, examine cell p (index r*4+c). If it is 0, write 1 when the latched rnd[4]=0, or 2 when it is 1, then go to DONE. Otherwise p<=p+1 mod 16.
  - If SPAWN_SCAN cells are examined with no empty cell, go to DONE with no write. This is defensive; a changed board always has an empty cell.
- DONE: done=1 and moved=changed for exactly one cycle, then IDLE. move_ready is 0 in PROC, SPAWN and DONE.
- won: registered. Set on any cycle where a cell of board equals WIN_EXP; cleared only by reset or load.
- Latency:
  - move accepted -> done = 4 (PROC) + 1 (DONE) cycles when unchanged.
  - Changed board: 4 + s + 1 cycles, s = 1..16 spawn scan cycles.
- Exponent overflow is the merge unit's concern; the block does no saturation.

Test Plan:
- Reset mid-PROC (assert rst_n=0 on cycle 2 of a move) -> board=0, move_ready=1, done=0 immediately, without waiting for a clock edge.
- Load row0 = cells {1,1,0,0} (c0..c3), rest 0; rnd=5'b0_0010; move left -> row0 = {2,0,0,0}; cell 2 (0,2) = 1; done after 4+1+1 cycles; moved=1.
- Load the same board, move down with rnd start=0 -> (3,0)=1, (3,1)=1; scan finds cell 0 empty in 1 cycle; (0,0)=1 (rnd[4]=0) or 2 (rnd[4]=1).
- Load full checkerboard of 1/2 with no merges possible; move right -> moved=0; board unchanged; done 5 cycles after accept; no spawn.
- Load row0 = {10,10,0,0}; move left -> row0 c0=11, won=1 and stays 1 after further moves; a later load clears won.
- Assert load_valid and move_valid together in IDLE -> board=load_board, no move executed, move_ready stays 1. Assert load_valid during PROC -> ignored.

Source files
------------

// File: rtl/game_move_sequencer.sv
// Owns the 4x4 2048 board and drives one shared combinational merge unit,
// one line per cycle, then spawns a tile in an empty cell after a changing move.
module game_move_sequencer #(
  parameter int         SPAWN_SCAN = 16,
  parameter logic [3:0] WIN_EXP    = 4'd11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  output logic        move_ready,
  input  logic        load_valid,
  input  logic [63:0] load_board,
  input  logic [4:0]  rnd,
  output logic [15:0] merge_row,
  output logic        merge_push_right,
  input  logic [15:0] merge_result,
  output logic [63:0] board,
  output logic        done,
  output logic        moved,
  output logic        won
);

  localparam int CNT_W = $clog2(SPAWN_SCAN + 1);

  typedef enum logic [1:0] {S_IDLE, S_PROC, S_SPAWN, S_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [63:0]        r_board, w_board_next;
  logic [1:0]         r_dir;
  logic [1:0]         r_k;
  logic               r_changed;
  logic [3:0]         r_scan_p;
  logic [CNT_W-1:0]   r_scan_cnt;
  logic               r_spawn_val;
  logic               r_won;

  logic [15:0]        w_line;
  logic               w_push_right;
  logic               w_line_diff;
  logic [3:0]         w_scan_cell;
  logic               w_scan_empty;
  logic               w_win_hit;
  logic               w_accept;

  // Gather the active line: rows for left/right, columns for up/down.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_line       = '0;
    w_push_right = 1'b0;
    if (r_state == S_PROC) begin
      w_push_right = r_dir[0];
      if (!r_dir[1]) begin
        w_line = r_board[16*int'(r_k) +: 16];
      end else begin
        for (int r = 0; r < 4; r++)
          w_line[4*r +: 4] = r_board[4*(4*r + int'(r_k)) +: 4];
      end
    end
  end

  assign w_line_diff  = (merge_result != w_line);
  assign w_scan_cell  = r_board[4*int'(r_scan_p) +: 4];
  assign w_scan_empty = (w_scan_cell == 4'd0);
  assign w_accept     = (r_state == S_IDLE) && !load_valid && move_valid;

  always_comb begin
    w_win_hit = 1'b0;
    for (int i = 0; i < 16; i++)
      if (r_board[4*i +: 4] == WIN_EXP) w_win_hit = 1'b1;
  end

  always_comb begin
    w_board_next = r_board;
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (load_valid)      w_board_next = load_board;
        else if (move_valid) w_state_next = S_PROC;
      end
      S_PROC: begin
        if (!r_dir[1]) begin
          w_board_next[16*int'(r_k) +: 16] = merge_result;
        end else begin
          for (int r = 0; r < 4; r++)
            w_board_next[4*(4*r + int'(r_k)) +: 4] = merge_result[4*r +: 4];
        end
        // The last line's difference counts before the accumulator updates.
        if (r_k == 2'd3)
          w_state_next = (r_changed || w_line_diff) ? S_SPAWN : S_DONE;
      end
      S_SPAWN: begin
        if (w_scan_empty) begin
          w_board_next[4*int'(r_scan_p) +: 4] = {2'b00, r_spawn_val, ~r_spawn_val};
          w_state_next = S_DONE;
        end else if (r_scan_cnt == CNT_W'(SPAWN_SCAN - 1)) begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_board     <= '0;
      r_dir       <= '0;
      r_k         <= '0;
      r_changed   <= 1'b0;
      r_scan_p    <= '0;
      r_scan_cnt  <= '0;
      r_spawn_val <= 1'b0;
      r_won       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_board <= w_board_next;
      r_won   <= (r_state == S_IDLE && load_valid) ? 1'b0 : (r_won | w_win_hit);
      if (w_accept) begin
        r_dir     <= move_dir;
        r_k       <= '0;
        r_changed <= 1'b0;
      end
      if (r_state == S_PROC) begin
        r_k       <= r_k + 2'd1;
        r_changed <= r_changed | w_line_diff;
        if (r_k == 2'd3) begin
          r_scan_p    <= rnd[3:0];
          r_spawn_val <= rnd[4];
          r_scan_cnt  <= '0;
        end
      end
      if (r_state == S_SPAWN) begin
        r_scan_p   <= r_scan_p + 4'd1;
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
    end
  end

  assign move_ready       = (r_state == S_IDLE);
  assign done             = (r_state == S_DONE);
  assign moved            = (r_state == S_DONE) && r_changed;
  assign merge_row        = w_line;
  assign merge_push_right = w_push_right;
  assign board            = r_board;
  assign won              = r_won;

endmodule

// File: tb/tb_game_move_sequencer.sv
// Self-checking bench: behavioural merge unit plus a move/spawn reference model
// feeding a scoreboard of expected board, moved flag and latency.
module tb_game_move_sequencer;

  logic        clk;
  logic        rst_n;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic        move_ready;
  logic        load_valid;
  logic [63:0] load_board;
  logic [4:0]  rnd;
  logic [15:0] merge_row;
  logic        merge_push_right;
  logic [15:0] merge_result;
  logic [63:0] board;
  logic        done;
  logic        moved;
  logic        won;

  typedef struct {
    logic [63:0] board;
    logic        moved;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_err;
  int   n_chk;

  game_move_sequencer #(.SPAWN_SCAN(16), .WIN_EXP(4'd11)) dut (
    .clk(clk), .rst_n(rst_n),
    .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
    .load_valid(load_valid), .load_board(load_board), .rnd(rnd),
    .merge_row(merge_row), .merge_push_right(merge_push_right),
    .merge_result(merge_result),
    .board(board), .done(done), .moved(moved), .won(won)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 2048 line merge: compact toward the push side, merge equal neighbours once.
  function automatic logic [15:0] merge_line(input logic [15:0] line, input logic right);
    logic [3:0] v[4];
    logic [3:0] t[4];
    logic [3:0] o[4];
    logic [15:0] res;
    int j;
    int n;
    int i;
    for (int a = 0; a < 4; a++) begin
      v[a] = right ? line[4*(3-a) +: 4] : line[4*a +: 4];
      t[a] = 4'd0;
      o[a] = 4'd0;
    end
    j = 0;
    for (int a = 0; a < 4; a++)
      if (v[a] != 4'd0) begin
        t[j] = v[a];
        j++;
      end
    n = 0;
    i = 0;
    while (i < j) begin
      if (i < j - 1 && t[i] == t[i+1]) begin
        o[n] = t[i] + 4'd1;
        i += 2;
      end else begin
        o[n] = t[i];
        i += 1;
      end
      n++;
    end
    res = '0;
    for (int a = 0; a < 4; a++)
      if (right) res[4*(3-a) +: 4] = o[a];
      else       res[4*a +: 4]     = o[a];
    return res;
  endfunction

  assign merge_result = merge_line(merge_row, merge_push_right);

  task automatic model_move(input logic [63:0] b, input logic [1:0] d, input logic [4:0] r,
                            output logic [63:0] nb, output logic mv, output int lat);
    logic [15:0] line;
    logic [15:0] res;
    int p;
    int s;
    nb = b;
    for (int k = 0; k < 4; k++) begin
      line = '0;
      for (int c = 0; c < 4; c++)
        line[4*c +: 4] = d[1] ? nb[4*(4*c + k) +: 4] : nb[4*(4*k + c) +: 4];
      res = merge_line(line, d[0]);
      for (int c = 0; c < 4; c++)
        if (d[1]) nb[4*(4*c + k) +: 4] = res[4*c +: 4];
        else      nb[4*(4*k + c) +: 4] = res[4*c +: 4];
    end
    mv  = (nb != b);
    lat = 4;
    if (mv) begin
      s = 16;
      p = int'(r[3:0]);
      for (int i = 0; i < 16; i++) begin
        if (nb[4*p +: 4] == 4'd0) begin
          nb[4*p +: 4] = r[4] ? 4'd2 : 4'd1;
          s = i + 1;
          break;
        end
        p = (p + 1) % 16;
      end
      lat = 4 + s;
    end
  endtask

  task automatic do_load(input logic [63:0] b);
    @(negedge clk);
    load_valid = 1'b1;
    load_board = b;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Issue one move, push the model's prediction, and check it when done fires.
  task automatic run_move(input logic [1:0] d, input logic [4:0] r, input bit inject_load);
    exp_t e;
    int   lat;
    bit   found;
    @(negedge clk);
    move_valid = 1'b1;
    move_dir   = d;
    rnd        = r;
    model_move(board, d, r, e.board, e.moved, e.lat);
    sb.push_back(e);
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    n_chk++;
    if (move_ready !== 1'b0) begin
      n_err++;
      $display("FAIL move_ready_busy: got %b want 0", move_ready);
    end
    if (inject_load) begin
      load_valid = 1'b1;
      load_board = 64'h1111_2222_3333_4444;
    end
    lat   = 0;
    found = 1'b0;
    while (lat < 40 && !found) begin
      @(posedge clk);
      #1;
      lat++;
      load_valid = 1'b0;
      if (done === 1'b1) found = 1'b1;
    end
    e = sb.pop_front();
    n_chk++;
    if (!found) begin
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles, want %0d", lat, e.lat);
    end else begin
      n_chk += 2;
      if (board !== e.board) begin
        n_err++;
        $display("FAIL move_board: got %h want %h", board, e.board);
      end
      if (moved !== e.moved) begin
        n_err++;
        $display("FAIL move_moved: got %b want %b", moved, e.moved);
      end
      if (lat !== e.lat) begin
        n_err++;
        $display("FAIL move_latency: got %0d want %0d", lat, e.lat);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (done !== 1'b0 || move_ready !== 1'b1) begin
        n_err++;
        $display("FAIL done_pulse: done=%b ready=%b want 0/1", done, move_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_chk++;
    if (board !== 64'd0 || move_ready !== 1'b1 || done !== 1'b0 || moved !== 1'b0 ||
        won !== 1'b0 || merge_row !== 16'd0 || merge_push_right !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: board=%h ready=%b done=%b moved=%b won=%b row=%h pr=%b",
               board, move_ready, done, moved, won, merge_row, merge_push_right);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_move_left();
    do_load(64'h0000_0000_0000_0011);
    run_move(2'd0, 5'b0_0010, 1'b0);
    n_chk++;
    if (board !== 64'h0000_0000_0000_0102) begin
      n_err++;
      $display("FAIL left_const: got %h want %h", board, 64'h0000_0000_0000_0102);
    end
  endtask

  task automatic test_move_down();
    do_load(64'h0000_0000_0000_0011);
    run_move(2'd3, 5'b1_0000, 1'b0);
    n_chk++;
    if (board !== 64'h0011_0000_0000_0002) begin
      n_err++;
      $display("FAIL down_const: got %h want %h", board, 64'h0011_0000_0000_0002);
    end
  endtask

  task automatic test_no_merge();
    logic [63:0] cb;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        cb[4*(4*r + c) +: 4] = ((r + c) % 2 == 1) ? 4'd2 : 4'd1;
    do_load(cb);
    run_move(2'd1, 5'b0_0000, 1'b0);
    n_chk++;
    if (board !== cb) begin
      n_err++;
      $display("FAIL nomerge_board: got %h want %h", board, cb);
    end
  endtask

  task automatic test_won();
    do_load(64'h0000_0000_0000_00AA);
    n_chk++;
    if (won !== 1'b0) begin
      n_err++;
      $display("FAIL won_before: got %b want 0", won);
    end
    run_move(2'd0, 5'b0_0101, 1'b0);
    n_chk++;
    if (won !== 1'b1 || board[3:0] !== 4'd11) begin
      n_err++;
      $display("FAIL won_set: won=%b cell0=%0d want 1/11", won, board[3:0]);
    end
    run_move(2'd1, 5'b0_0000, 1'b0);
    n_chk++;
    if (won !== 1'b1) begin
      n_err++;
      $display("FAIL won_sticky: got %b want 1", won);
    end
    do_load(64'h0000_0000_0000_0001);
    n_chk++;
    if (won !== 1'b0) begin
      n_err++;
      $display("FAIL won_clear: got %b want 0", won);
    end
  endtask

  task automatic test_load_priority();
    bit saw_done;
    @(negedge clk);
    load_valid = 1'b1;
    load_board = 64'h0000_0000_0000_0012;
    move_valid = 1'b1;
    move_dir   = 2'd0;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    move_valid = 1'b0;
    n_chk++;
    if (board !== 64'h0000_0000_0000_0012 || move_ready !== 1'b1) begin
      n_err++;
      $display("FAIL load_prio: board=%h ready=%b want %h/1", board, move_ready,
               64'h0000_0000_0000_0012);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || move_ready !== 1'b1) saw_done = 1'b1;
    end
    n_chk++;
    if (saw_done || board !== 64'h0000_0000_0000_0012) begin
      n_err++;
      $display("FAIL load_prio_nomove: busy=%b board=%h want 0/%h", saw_done, board,
               64'h0000_0000_0000_0012);
    end
  endtask

  task automatic test_load_during_proc();
    do_load(64'h0000_0000_0030_0303);
    run_move(2'd2, 5'b0_0111, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [63:0] b;
    for (int t = 0; t < 4; t++) begin
      b = '0;
      for (int i = 0; i < 16; i++)
        if ($urandom_range(1, 0) == 1) b[4*i +: 4] = 4'($urandom_range(3, 1));
      do_load(b);
      for (int m = 0; m < 3; m++)
        run_move(2'($urandom_range(3, 0)), 5'($urandom_range(31, 0)), 1'b0);
    end
  endtask

  task automatic test_reset_mid_proc();
    do_load(64'h0000_0000_0000_0011);
    @(negedge clk);
    move_valid = 1'b1;
    move_dir   = 2'd0;
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (board !== 64'd0 || move_ready !== 1'b1 || done !== 1'b0 || merge_row !== 16'd0) begin
      n_err++;
      $display("FAIL reset_mid_proc: board=%h ready=%b done=%b row=%h", board, move_ready,
               done, merge_row);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_load(64'h0000_0000_0000_0011);
    run_move(2'd0, 5'b0_0010, 1'b0);
  endtask

  initial begin
    n_err      = 0;
    n_chk      = 0;
    move_valid = 1'b0;
    move_dir   = 2'd0;
    load_valid = 1'b0;
    load_board = '0;
    rnd        = '0;
    test_reset();
    test_move_left();
    test_move_down();
    test_no_merge();
    test_won();
    test_load_priority();
    test_load_during_proc();
    test_back_to_back();
    test_reset_mid_proc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
